// File: rtl/dsp_mult_pipe.sv
// Pipelined MAC32 / MSU32 / DOT8 / DOT16 multiplier with valid/ready handshake,
// pass-through tag, optional signed saturation of dot results and synchronous flush.
module dsp_mult_pipe #(
    parameter int NUM_STAGES = 2,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2:0]           operator_i,
    input  logic [31:0]          op_a_i,
    input  logic [31:0]          op_b_i,
    input  logic [31:0]          op_c_i,
    input  logic [1:0]           dot_signed_i,
    input  logic                 sat_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          result_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 sat_flag_o
);

    localparam logic [2:0] MUL_MAC32 = 3'b000;
    localparam logic [2:0] MUL_MSU32 = 3'b001;
    localparam logic [2:0] MUL_DOT8  = 3'b100;
    localparam logic [2:0] MUL_DOT16 = 3'b101;

    typedef struct packed {
        logic [31:0]          result;
        logic                 sat;
        logic [TAG_WIDTH-1:0] tag;
    } stage_t;

    logic [31:0]        prod32;
    logic signed [8:0]  a9, b9;
    logic signed [17:0] p18;
    logic signed [16:0] a17, b17;
    logic signed [33:0] p34;
    logic signed [35:0] dot_sum;
    logic               is_dot;
    logic [31:0]        res;
    logic               sat_flag;
    stage_t             stage_in;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        prod32   = op_a_i * op_b_i;
        dot_sum  = {{4{op_c_i[31]}}, op_c_i};
        a9       = '0;
        b9       = '0;
        p18      = '0;
        a17      = '0;
        b17      = '0;
        p34      = '0;
        is_dot   = 1'b0;
        res      = '0;
        sat_flag = 1'b0;
        case (operator_i)
            MUL_MAC32: res = op_c_i + prod32;
            MUL_MSU32: res = op_c_i - prod32;
            MUL_DOT8: begin
                is_dot = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    a9      = {dot_signed_i[1] & op_a_i[8*i+7], op_a_i[8*i +: 8]};
                    b9      = {dot_signed_i[0] & op_b_i[8*i+7], op_b_i[8*i +: 8]};
                    p18     = a9 * b9;
                    dot_sum = dot_sum + {{18{p18[17]}}, p18};
                end
            end
            MUL_DOT16: begin
                is_dot = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    a17     = {dot_signed_i[1] & op_a_i[16*i+15], op_a_i[16*i +: 16]};
                    b17     = {dot_signed_i[0] & op_b_i[16*i+15], op_b_i[16*i +: 16]};
                    p34     = a17 * b17;
                    dot_sum = dot_sum + {{2{p34[33]}}, p34};
                end
            end
            default: res = '0;
        endcase
        // Out of signed 32-bit range exactly when the bits above bit 31 disagree with the sign.
        if (is_dot) begin
            res = dot_sum[31:0];
            if (sat_i && (dot_sum[35:31] != {5{dot_sum[35]}})) begin
                sat_flag = 1'b1;
                res      = dot_sum[35] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end
        stage_in = '{result: res, sat: sat_flag, tag: tag_i};
    end

    logic [NUM_STAGES-1:0] valid_q, valid_d, load;
    stage_t                data_q [NUM_STAGES];
    stage_t                data_d [NUM_STAGES];

    // A stage can load when out_ready_i is high or any stage from it to the output is empty.
    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            load[k] = out_ready_i;
            for (int j = k; j < NUM_STAGES; j++) begin
                if (!valid_q[j]) load[k] = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < NUM_STAGES; k++) data_d[k] = data_q[k];
        if (load[0]) begin
            valid_d[0] = in_valid_i;
            data_d[0]  = stage_in;
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (load[k]) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = data_q[k-1];
            end
        end
        if (flush_i) valid_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all stages update together at the edge.
    // NOTE: the data registers are reset as well because the presented result, tag and flag must read 0 in reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int k = 0; k < NUM_STAGES; k++) data_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < NUM_STAGES; k++) data_q[k] <= data_d[k];
        end
    end

    assign in_ready_o  = load[0];
    assign out_valid_o = valid_q[NUM_STAGES-1];
    assign result_o    = data_q[NUM_STAGES-1].result;
    assign tag_o       = data_q[NUM_STAGES-1].tag;
    assign sat_flag_o  = data_q[NUM_STAGES-1].sat;

endmodule

// File: tb/tb_dsp_mult_pipe.sv
// Directed self-checking bench for dsp_mult_pipe with NUM_STAGES=2: arithmetic,
// saturation, back-pressure ordering, flush and asynchronous reset.
module tb_dsp_mult_pipe;

    localparam int TW = 5;
    localparam logic [2:0] MAC = 3'b000;
    localparam logic [2:0] MSU = 3'b001;
    localparam logic [2:0] DOT8 = 3'b100;
    localparam logic [2:0] DOT16 = 3'b101;
    localparam logic [2:0] OTHER = 3'b010;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [31:0]   a, b, c;
    logic [1:0]    ds;
    logic          sat;
    logic [TW-1:0] tag_in;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   result;
    logic [TW-1:0] tag_out;
    logic          sat_flag;

    int checks = 0;
    int failures = 0;

    dsp_mult_pipe #(.NUM_STAGES(2), .TAG_WIDTH(TW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .operator_i  (op),
        .op_a_i      (a),
        .op_b_i      (b),
        .op_c_i      (c),
        .dot_signed_i(ds),
        .sat_i       (sat),
        .tag_i       (tag_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .tag_o       (tag_out),
        .sat_flag_o  (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] vc, input logic [1:0] vds, input logic vsat,
                         input logic [TW-1:0] vtag);
        op = o; a = va; b = vb; c = vc; ds = vds; sat = vsat; tag_in = vtag;
    endtask

    // Issue one op into an empty pipeline with out_ready=1 and check the 2-cycle latency.
    task automatic run_single(input string name, input logic [2:0] o, input logic [31:0] va,
                              input logic [31:0] vb, input logic [31:0] vc, input logic [1:0] vds,
                              input logic vsat, input logic [TW-1:0] vtag,
                              input logic [31:0] exp_res, input logic exp_sat);
        @(negedge clk);
        drive(o, va, vb, vc, vds, vsat, vtag);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check({name, "_in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({name, "_valid_c1"}, out_valid, 1'b0);
        @(negedge clk);
        #1;
        check({name, "_valid_c2"}, out_valid, 1'b1);
        check({name, "_result"}, result, exp_res);
        check({name, "_tag"}, tag_out, vtag);
        check({name, "_sat"}, sat_flag, exp_sat);
    endtask

    initial begin
        int issued, delivered, occ;
        logic held, in_x, out_x;
        logic [31:0] held_res;
        logic [TW-1:0] held_tag;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(MAC, 0, 0, 0, 2'b00, 1'b0, '0);
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_tag", tag_out, 0);
        check("rst_sat", sat_flag, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_in_ready", in_ready, 1'b1);

        run_single("mac", MAC, 3, 5, 10, 2'b00, 1'b0, 5'd7, 32'h0000_0019, 1'b0);
        run_single("msu", MSU, 3, 5, 10, 2'b00, 1'b0, 5'd8, 32'hFFFF_FFFB, 1'b0);
        run_single("dot8_ss", DOT8, 32'h8080_8080, 32'h8080_8080, 0, 2'b11, 1'b0, 5'd9, 32'h0001_0000, 1'b0);
        run_single("dot8_uu", DOT8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2'b00, 1'b0, 5'd10, 32'h0003_F804, 1'b0);
        run_single("dot8_su", DOT8, 32'h0000_00FF, 32'h0000_00FF, 0, 2'b10, 1'b0, 5'd11, 32'hFFFF_FF01, 1'b0);
        run_single("dot16_satpos", DOT16, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF, 2'b11, 1'b1, 5'd12, 32'h7FFF_FFFF, 1'b1);
        run_single("dot16_wrap", DOT16, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF, 2'b11, 1'b0, 5'd13, 32'hFFFF_FFFF, 1'b0);
        run_single("dot16_satneg", DOT16, 32'h0000_8000, 32'h0000_7FFF, 32'h8000_0000, 2'b11, 1'b1, 5'd14, 32'h8000_0000, 1'b1);
        run_single("mac_nosat", MAC, 32'h0001_0000, 32'h0001_0000, 5, 2'b11, 1'b1, 5'd15, 32'h0000_0005, 1'b0);
        run_single("other_op", OTHER, 3, 5, 10, 2'b11, 1'b1, 5'd16, 32'h0, 1'b0);

        // Back-pressure: out_ready pattern 0,0,0,1; occupancy model predicts in_ready.
        issued = 0; delivered = 0; occ = 0; held = 1'b0; held_res = '0; held_tag = '0;
        for (int cyc = 0; cyc < 60 && delivered < 6; cyc++) begin
            @(negedge clk);
            out_ready = ((cyc % 4) == 3);
            if (issued < 6) begin
                drive(MAC, issued, 7, 100, 2'b00, 1'b0, TW'(issued));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("bp_in_ready", in_ready, (occ < 2) || out_ready);
            if (held) begin
                check("bp_hold_valid", out_valid, 1'b1);
                check("bp_hold_result", result, held_res);
                check("bp_hold_tag", tag_out, held_tag);
            end
            in_x  = in_valid & in_ready;
            out_x = out_valid & out_ready;
            if (out_x) begin
                check("bp_order_tag", tag_out, TW'(delivered));
                check("bp_result", result, 32'(100 + 7 * delivered));
                delivered++;
            end
            if (in_x) issued++;
            held     = out_valid & ~out_ready;
            held_res = result;
            held_tag = tag_out;
            occ      = occ + int'(in_x) - int'(out_x);
        end
        in_valid = 1'b0;
        check("bp_delivered", delivered, 6);

        // Flush with two in flight plus a simultaneous input transfer.
        @(negedge clk);
        out_ready = 1'b1;
        drive(MAC, 1, 1, 0, 2'b00, 1'b0, 5'd20);
        in_valid = 1'b1;
        @(negedge clk);
        drive(MAC, 2, 1, 0, 2'b00, 1'b0, 5'd21);
        @(negedge clk);
        drive(MAC, 3, 1, 0, 2'b00, 1'b0, 5'd22);
        flush = 1'b1;
        #1 check("flush_in_ready", in_ready, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1 check("flush_valid_next", out_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("flush_no_output", out_valid, 1'b0);
        end
        run_single("post_flush", MAC, 6, 7, 1, 2'b00, 1'b0, 5'd23, 32'h0000_002B, 1'b0);

        // Asynchronous reset with the pipeline full.
        @(negedge clk);
        out_ready = 1'b0;
        drive(DOT16, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF, 2'b11, 1'b1, 5'd24);
        in_valid = 1'b1;
        @(negedge clk);
        drive(MAC, 9, 9, 9, 2'b00, 1'b0, 5'd25);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_in_ready", in_ready, 1'b0);
        check("full_out_valid", out_valid, 1'b1);
        check("full_sat", sat_flag, 1'b1);
        check("full_tag", tag_out, 5'd24);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_result", result, 32'h0);
        check("arst_tag", tag_out, 0);
        check("arst_sat", sat_flag, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_idle", out_valid, 1'b0);
        run_single("post_reset", MAC, 2, 2, 0, 2'b00, 1'b0, 5'd3, 32'h0000_0004, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_mult_pipe.md
Name: dsp_mult_pipe

Overview:
- Pipelined successor of the shared integer/dot-product multiplier in the APU cluster integer units.
- Executes MAC32, MSU32, DOT8 and DOT16 behind a valid/ready handshake, with a configurable register depth, a pass-through tag, optional signed saturation of dot results, and a synchronous flush.
- Sits between the APU interconnect arbiter and the result write-back path.

Parameters:
- NUM_STAGES, 2, number of register stages between input and output, legal range 1..4; this is the latency in cycles.
- TAG_WIDTH, 5, width of the opaque tag carried alongside each operation.

Ports:
- clk_i  in  1  clock, all state rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous; kills every in-flight operation.
- in_valid_i  in  1  an operation is offered at the input.
- in_ready_o  out  1  the pipeline accepts the offered operation this cycle.
- operator_i  in  3  uses the riscv_defines_apu constants MUL_MAC32, MUL_MSU32, MUL_DOT8, MUL_DOT16.
- op_a_i  in  32  operand A.
- op_b_i  in  32  operand B.
- op_c_i  in  32  accumulator operand.
- dot_signed_i  in  2  bit1 = A lanes signed, bit0 = B lanes signed; DOT operations only.
- sat_i  in  1  saturate the DOT result to signed 32-bit.
- tag_i  in  TAG_WIDTH  tag for the operation.
- out_valid_o  out  1  a result is presented at the output.
- out_ready_i  in  1  the consumer takes the presented result.
- result_o  out  32  result.
- tag_o  out  TAG_WIDTH  tag of the presented result.
- sat_flag_o  out  1  saturation occurred for the presented result.

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-high, rst_i.
- Reset: all stage-valid bits 0. out_valid_o=0, result_o=0, tag_o=0, sat_flag_o=0. in_ready_o=1 once rst_i deasserts. Asserting rst_i mid-operation drops all in-flight work and produces no output.
- Transfers: input transfer when in_valid_i & in_ready_o; output transfer when out_valid_o & out_ready_i.
- Pipeline control:
  - Stage k (0..NUM_STAGES-1) holds valid_k, data_k and tag_k.
  - Stage k loads when it is empty or stage k+1 loads; the last stage loads when it is empty or out_ready_i=1.
  - in_ready_o = stage-0 load condition. This is combinational from out_ready_i through the chain; no skid buffer.
- Throughput and latency: with out_ready_i held at 1, one operation per cycle; the result appears exactly NUM_STAGES cycles after acceptance.
- Order and hold: results leave strictly in issue order. With out_ready_i=0, result_o, tag_o and sat_flag_o hold stable while out_valid_o=1.
- Datapath: computed combinationally from the input ports and captured into stage 0; later stages are pure registers. Synthesis retiming is allowed.
- Operations:
  - MUL_MAC32: c + a*b, modulo 2^32.
  - MUL_MSU32: c - a*b, modulo 2^32.
  - MUL_DOT8: four byte lanes. Each lane is extended to 9 bits (sign bit = dot_signed & lane MSB); lane products are summed with c.
  - MUL_DOT16: two half-word lanes, extended to 17 bits the same way, products summed with c.
  - Any other operator code: result 0, sat flag 0, still handshaked and tagged normally.
- DOT arithmetic: the sum is formed exactly in 36-bit signed (c sign-extended).
  - sat_i=0: result = sum[31:0] (wraps), sat flag 0.
  - sat_i=1 and sum > 2^31-1: result 0x7FFFFFFF, flag 1.
  - sat_i=1 and sum < -2^31: result 0x80000000, flag 1.
  - sat_i=1 and sum in range: result = sum[31:0], flag 0.
- sat_i is ignored for MAC32 and MSU32 (flag 0).
- Flush:
  - flush_i=1 clears every valid bit at the next edge; out_valid_o=0 the following cycle.
  - An input transfer in the flush cycle is also discarded.
  - Data registers need not be cleared.
  - flush_i takes precedence over simultaneous accept and output transfers.
- Back-pressure example, out_ready_i=0: with NUM_STAGES=2 the pipeline holds exactly 2 operations, then in_ready_o=0. No loss and no duplication when out_ready_i returns to 1.

Test Plan:
- MUL_MAC32 a=3, b=5, c=10, out_ready_i=1, NUM_STAGES=2 -> result 0x00000019 with tag matching the input, 2 cycles after acceptance.
- MUL_MSU32 a=3, b=5, c=10 -> 0xFFFFFFFB. MUL_DOT8 dot_signed=11, a=b=0x80808080, c=0 -> 0x00010000. MUL_DOT8 dot_signed=00, a=b=0xFFFFFFFF, c=0 -> 0x0003F804.
- MUL_DOT16 dot_signed=11, a=b=0x80008000, c=0x7FFFFFFF: sat_i=1 -> result 0x7FFFFFFF, sat_flag 1; sat_i=0 -> result 0xFFFFFFFF, sat_flag 0.
- Back-pressure: stream 6 tagged ops (tags 0..5) with out_ready_i toggling 0,0,0,1 repeating -> in_ready_o drops after 2 ops are held, all 6 results delivered in tag order with no gaps or repeats, and results stay stable while stalled.
- Flush with 2 ops in flight plus a simultaneous input transfer -> out_valid_o=0 the next cycle, none of the 3 results ever appear, and the next op issued completes normally.
- Assert rst_i asynchronously between clock edges with the pipeline full -> out_valid_o falls immediately and all outputs are 0. After release, in_ready_o=1 and MAC32 a=2, b=2, c=0 gives 0x00000004.
